// File: rtl/dbg_slave_bridge_if.sv
// dbg_slave_bridge_if: JTAG-side strobes and channel-side bus of the
// debug-slave command bridge, grouped with master/slave modports.
interface dbg_slave_bridge_if #(
    parameter int IR_WIDTH = 2,
    parameter int NUM_CH   = 4,
    parameter int DR_WIDTH = 38,
    parameter int RD_WIDTH = 32
) ();
    logic [IR_WIDTH-1:0]        ir_in;
    logic                       update_ir;
    logic                       capture_dr;
    logic                       shift_dr;
    logic                       update_dr;
    logic                       tdi;
    logic                       tdo;
    logic [NUM_CH*RD_WIDTH-1:0] ch_rdata;
    logic [NUM_CH*2-1:0]        ch_status;
    logic [NUM_CH-1:0]          ch_ready;
    logic [DR_WIDTH-1:0]        jdo;
    logic [NUM_CH-1:0]          take_action;
    logic [NUM_CH-1:0]          take_no_action;
    logic                       busy;
    logic                       overrun;
    logic                       timeout;

    modport master (
        output ir_in, update_ir, capture_dr, shift_dr, update_dr, tdi,
        output ch_rdata, ch_status, ch_ready,
        input  tdo, jdo, take_action, take_no_action,
        input  busy, overrun, timeout
    );

    modport slave (
        input  ir_in, update_ir, capture_dr, shift_dr, update_dr, tdi,
        input  ch_rdata, ch_status, ch_ready,
        output tdo, jdo, take_action, take_no_action,
        output busy, overrun, timeout
    );
endinterface

// File: rtl/dbg_slave_bridge.sv
// dbg_slave_bridge: debug DR shift chain, IR latch and per-channel command
// issue with ready handshake. Optional timeout via DBG_BRIDGE_TIMEOUT_EN.
module dbg_slave_bridge #(
    parameter int IR_WIDTH    = 2,
    parameter int NUM_CH      = 4,
    parameter int DR_WIDTH    = 38,
    parameter int RD_WIDTH    = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input logic               clk,
    input logic               reset,
    dbg_slave_bridge_if.slave bus
);

    if (NUM_CH < 1 || NUM_CH > (1 << IR_WIDTH)) begin : g_bad_num_ch
        $error("NUM_CH must be in 1..2**IR_WIDTH");
    end
    if (DR_WIDTH < RD_WIDTH + 2) begin : g_bad_dr_width
        $error("DR_WIDTH must be at least RD_WIDTH+2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FIRE
    } state_t;

    state_t              state;
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] cmd_ch;
    logic                cmd_act;
    logic [DR_WIDTH-1:0] sr;
    logic [DR_WIDTH-1:0] jdo_q;
    logic [DR_WIDTH-1:0] cap_word;
    logic [NUM_CH-1:0]   act_q;
    logic [NUM_CH-1:0]   noact_q;
    logic [NUM_CH-1:0]   ch_hot;
    logic [RD_WIDTH-1:0] rdata_sel;
    logic [1:0]          status_sel;
    logic                ir_ok;
    logic                ready_sel;
    logic                upd;
    logic                overrun_q;

`ifdef DBG_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             timeout_q;
`endif

    // Capture word for the channel selected by the latched IR
    always_comb begin
        ir_ok      = {1'b0, ir_q} < (IR_WIDTH + 1)'(NUM_CH);
        rdata_sel  = '0;
        status_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ir_q == IR_WIDTH'(c)) begin
                rdata_sel  = bus.ch_rdata[c*RD_WIDTH +: RD_WIDTH];
                status_sel = bus.ch_status[c*2 +: 2];
            end
        end
        cap_word = '0;
        if (ir_ok) begin
            cap_word[DR_WIDTH-1 -: 2]  = status_sel;
            cap_word[RD_WIDTH-1:0]     = rdata_sel;
        end
    end

    // Ready and one-hot strobe vector of the pending command channel
    always_comb begin
        ready_sel = 1'b0;
        ch_hot    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cmd_ch == IR_WIDTH'(c)) begin
                ready_sel = bus.ch_ready[c];
                ch_hot[c] = 1'b1;
            end
        end
    end

    // Update only counts when neither capture nor shift claims the cycle
    assign upd = bus.update_dr & ~bus.capture_dr & ~bus.shift_dr;

    // Shift chain: capture beats shift; shifting is LSB-first toward tdo
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (bus.capture_dr) begin
            sr <= cap_word;
        end else if (bus.shift_dr) begin
            sr <= {bus.tdi, sr[DR_WIDTH-1:1]};
        end
    end

    // Instruction latch
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q <= '0;
        end else if (bus.update_ir) begin
            ir_q <= bus.ir_in;
        end
    end

    // Command FSM: commit, wait for ready, fire a one-cycle strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            jdo_q     <= '0;
            cmd_ch    <= '0;
            cmd_act   <= 1'b0;
            act_q     <= '0;
            noact_q   <= '0;
            overrun_q <= 1'b0;
`ifdef DBG_BRIDGE_TIMEOUT_EN
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            act_q   <= '0;
            noact_q <= '0;
            if (bus.update_ir) begin
                overrun_q <= 1'b0;
`ifdef DBG_BRIDGE_TIMEOUT_EN
                timeout_q <= 1'b0;
`endif
            end
            unique case (state)
                IDLE: begin
                    if (upd) begin
                        jdo_q <= sr;
                        if (ir_ok) begin
                            cmd_ch  <= ir_q;
                            cmd_act <= sr[DR_WIDTH-1];
                            state   <= PEND;
`ifdef DBG_BRIDGE_TIMEOUT_EN
                            tmo_cnt <= '0;
`endif
                        end
                    end
                end
                PEND: begin
                    if (ready_sel) begin
                        state <= FIRE;
                        if (cmd_act) begin
                            act_q <= ch_hot;
                        end else begin
                            noact_q <= ch_hot;
                        end
                    end
`ifdef DBG_BRIDGE_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                FIRE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // A commit attempt while a command is outstanding is dropped
            if (upd && state != IDLE) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.tdo            = sr[0];
    assign bus.jdo            = jdo_q;
    assign bus.take_action    = act_q;
    assign bus.take_no_action = noact_q;
    assign bus.busy           = (state != IDLE);
    assign bus.overrun        = overrun_q;
`ifdef DBG_BRIDGE_TIMEOUT_EN
    assign bus.timeout        = timeout_q;
`else
    assign bus.timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_dbg_slave_bridge.sv
// tb_dbg_slave_bridge: directed test of dbg_slave_bridge (NUM_CH=3).
// Optional timeout scenario runs when DBG_BRIDGE_TIMEOUT_EN is defined.
module tb_dbg_slave_bridge;

    localparam int IRW = 2;
    localparam int NCH = 3;
    localparam int DRW = 38;
    localparam int RDW = 32;
    localparam int TMO = 8;
`ifdef DBG_BRIDGE_TIMEOUT_EN
    localparam int WAITC = 5;
`else
    localparam int WAITC = 10;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    dbg_slave_bridge_if #(
        .IR_WIDTH(IRW), .NUM_CH(NCH), .DR_WIDTH(DRW), .RD_WIDTH(RDW)
    ) bus ();

    dbg_slave_bridge #(
        .IR_WIDTH(IRW), .NUM_CH(NCH), .DR_WIDTH(DRW),
        .RD_WIDTH(RDW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ir(input logic [IRW-1:0] v);
        bus.ir_in     = v;
        bus.update_ir = 1'b1;
        tick();
        bus.update_ir = 1'b0;
    endtask

    task automatic shift_in(input logic [DRW-1:0] v);
        for (int i = 0; i < DRW; i++) begin
            bus.tdi      = v[i];
            bus.shift_dr = 1'b1;
            tick();
        end
        bus.shift_dr = 1'b0;
        bus.tdi      = 1'b0;
    endtask

    logic [DRW-1:0] cap_exp;
    logic [DRW-1:0] v_act;
    logic [DRW-1:0] v_na;
    logic [DRW-1:0] v_ov;
    logic           any_one;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.ir_in      = '0;
        bus.update_ir  = 1'b0;
        bus.capture_dr = 1'b0;
        bus.shift_dr   = 1'b0;
        bus.update_dr  = 1'b0;
        bus.tdi        = 1'b0;
        bus.ch_rdata   = {32'hCAFEF00D, 32'hDEADBEEF, 32'h11111111};
        bus.ch_status  = {2'b01, 2'b10, 2'b11};
        bus.ch_ready   = 3'b111;
        cap_exp = {2'b10, 4'b0000, 32'hDEADBEEF};
        v_act   = 38'h20_0000_0123;
        v_na    = 38'h0A_5A5A_5A5A;
        v_ov    = 38'h20_0000_00AA;

        // reset state
        tick();
        tick();
        chk("rst_tdo", 64'(bus.tdo), 64'd0);
        chk("rst_jdo", 64'(bus.jdo), 64'd0);
        chk("rst_act", 64'(bus.take_action), 64'd0);
        chk("rst_noact", 64'(bus.take_no_action), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ovr", 64'(bus.overrun), 64'd0);
        chk("rst_tmo", 64'(bus.timeout), 64'd0);
        reset = 1'b0;
        tick();

        // capture channel 1 and shift it out
        set_ir(2'd1);
        bus.capture_dr = 1'b1;
        tick();
        bus.capture_dr = 1'b0;
        for (int i = 0; i < DRW; i++) begin
            chk($sformatf("cap_bit%0d", i), 64'(bus.tdo), 64'(cap_exp[i]));
            bus.shift_dr = 1'b1;
            tick();
        end
        bus.shift_dr = 1'b0;

        // action strobe on channel 2
        set_ir(2'd2);
        shift_in(v_act);
        bus.update_dr = 1'b1;
        tick();
        bus.update_dr = 1'b0;
        chk("act_jdo", 64'(bus.jdo), 64'(v_act));
        chk("act_busy1", 64'(bus.busy), 64'd1);
        chk("act_early", 64'(bus.take_action), 64'd0);
        tick();
        chk("act_strobe", 64'(bus.take_action), 64'h4);
        chk("act_noact", 64'(bus.take_no_action), 64'd0);
        chk("act_busy2", 64'(bus.busy), 64'd1);
        tick();
        chk("act_off", 64'(bus.take_action), 64'd0);
        chk("act_idle", 64'(bus.busy), 64'd0);

        // no-action on channel 0 with ready held low
        set_ir(2'd0);
        bus.ch_ready = 3'b110;
        shift_in(v_na);
        bus.update_dr = 1'b1;
        tick();
        bus.update_dr = 1'b0;
        for (int i = 0; i < WAITC; i++) begin
            chk($sformatf("wait_busy%0d", i), 64'(bus.busy), 64'd1);
            chk($sformatf("wait_strb%0d", i),
                64'({bus.take_action, bus.take_no_action}), 64'd0);
            chk($sformatf("wait_tmo%0d", i), 64'(bus.timeout), 64'd0);
            tick();
        end
        bus.ch_ready = 3'b111;
        tick();
        chk("na_strobe", 64'(bus.take_no_action), 64'h1);
        chk("na_act", 64'(bus.take_action), 64'd0);
        chk("na_jdo", 64'(bus.jdo), 64'(v_na));
        tick();
        chk("na_off", 64'(bus.take_no_action), 64'd0);
        chk("na_idle", 64'(bus.busy), 64'd0);

        // overrun: second update one cycle later
        shift_in(v_ov);
        bus.update_dr = 1'b1;
        tick();
        chk("ov1_jdo", 64'(bus.jdo), 64'(v_ov));
        tick();
        bus.update_dr = 1'b0;
        chk("ov1_flag", 64'(bus.overrun), 64'd1);
        chk("ov1_strobe", 64'(bus.take_action), 64'h1);
        tick();
        chk("ov1_one", 64'(bus.take_action), 64'd0);
        chk("ov1_idle", 64'(bus.busy), 64'd0);
        chk("ov1_keep", 64'(bus.jdo), 64'(v_ov));
        set_ir(2'd0);
        chk("ov1_clr", 64'(bus.overrun), 64'd0);

        // overrun in strobe cycle, then accepted update at N+3
        bus.update_dr = 1'b1;
        tick();
        bus.update_dr = 1'b0;
        bus.shift_dr  = 1'b1;
        bus.tdi       = 1'b1;
        tick();
        bus.shift_dr  = 1'b0;
        bus.tdi       = 1'b0;
        chk("ov2_strobe", 64'(bus.take_action), 64'h1);
        bus.update_dr = 1'b1;
        tick();
        chk("ov2_flag", 64'(bus.overrun), 64'd1);
        chk("ov2_idle", 64'(bus.busy), 64'd0);
        chk("ov2_keep", 64'(bus.jdo), 64'(v_ov));
        tick();
        bus.update_dr = 1'b0;
        chk("n3_jdo", 64'(bus.jdo), 64'({1'b1, v_ov[DRW-1:1]}));
        chk("n3_busy", 64'(bus.busy), 64'd1);
        tick();
        chk("n3_strobe", 64'(bus.take_action), 64'h1);
        tick();
        chk("n3_idle", 64'(bus.busy), 64'd0);

        // out-of-range IR: zero capture, no command
        set_ir(2'd3);
        chk("oor_ovr_clr", 64'(bus.overrun), 64'd0);
        bus.capture_dr = 1'b1;
        tick();
        bus.capture_dr = 1'b0;
        any_one = 1'b0;
        for (int i = 0; i < DRW; i++) begin
            any_one      = any_one | bus.tdo;
            bus.shift_dr = 1'b1;
            tick();
        end
        bus.shift_dr = 1'b0;
        chk("oor_chain", 64'(any_one), 64'd0);
        bus.update_dr = 1'b1;
        tick();
        bus.update_dr = 1'b0;
        chk("oor_busy", 64'(bus.busy), 64'd0);
        chk("oor_jdo", 64'(bus.jdo), 64'd0);
        tick();
        chk("oor_strobe",
            64'({bus.take_action, bus.take_no_action}), 64'd0);

`ifdef DBG_BRIDGE_TIMEOUT_EN
        // pending command expires after TMO cycles without ready
        set_ir(2'd2);
        bus.ch_ready = 3'b000;
        shift_in(v_act);
        bus.update_dr = 1'b1;
        tick();
        bus.update_dr = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            chk($sformatf("tmo_busy%0d", k), 64'(bus.busy), 64'd1);
            chk($sformatf("tmo_flag%0d", k), 64'(bus.timeout), 64'd0);
            tick();
        end
        chk("tmo_set", 64'(bus.timeout), 64'd1);
        chk("tmo_idle", 64'(bus.busy), 64'd0);
        chk("tmo_strobe",
            64'({bus.take_action, bus.take_no_action}), 64'd0);
        bus.ch_ready = 3'b111;
        set_ir(2'd2);
        chk("tmo_clr", 64'(bus.timeout), 64'd0);
`endif

        // reset while pending: everything back to zero, no strobe
        set_ir(2'd1);
        bus.ch_ready = 3'b000;
        shift_in(v_act);
        bus.update_dr = 1'b1;
        tick();
        bus.update_dr = 1'b0;
        chk("mid_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_jdo", 64'(bus.jdo), 64'd0);
        chk("mid_rst_tdo", 64'(bus.tdo), 64'd0);
        bus.ch_ready = 3'b111;
        tick();
        chk("mid_rst_strobe",
            64'({bus.take_action, bus.take_no_action}), 64'd0);
        chk("mid_rst_idle", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
